branch_target_unit: RTL

- Pipelined, parametrised branch/jump target generator for the RV32I core. It sits between decode and the PC-select/fetch-redirect stage.
- Computes the target address and a branch-class flag from pc, rs1 and the immediate, with registered outputs and a valid/ready handshake.
- Adds a return-address stack (RAS) for call/return prediction and detects misaligned targets.

---
 rtl/btu_pkg.sv | 38 +++
 rtl/ras_stack.sv | 69 ++++++
 rtl/branch_target_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/btu_pkg.sv
// Shared definitions for the branch target unit.
//   instr_type_e : decoder instruction-format codes
//   flag_e       : branch class reported with each result
//   ras_op_e     : operation applied to the return-address stack
//   REG_RA/REG_T0: link registers for call/return hinting
package btu_pkg;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } instr_type_e;

  typedef enum logic [1:0] {
    FLAG_NONE = 2'b00,
    FLAG_JAL  = 2'b01,
    FLAG_JALR = 2'b10,
    FLAG_BR   = 2'b11
  } flag_e;

  typedef enum logic [1:0] {
    RAS_NONE    = 2'd0,
    RAS_PUSH    = 2'd1,
    RAS_POP     = 2'd2,
    RAS_POPPUSH = 2'd3
  } ras_op_e;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
//   clk, rst_n : clock, async active-low reset
//   op         : NONE / PUSH / POP / POPPUSH (apply this cycle)
//   push_data  : return address written on PUSH / POPPUSH
//   top        : most recently pushed live entry (combinational)
//   empty/full : occupancy is 0 / RAS_DEPTH
// A push on a full stack overwrites the oldest entry; occupancy saturates.
module ras_stack
  import btu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  ras_op_e         op,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] entries [RAS_DEPTH];
  logic [PW-1:0]   ptr;    // next free slot; top lives at ptr-1
  logic [CW-1:0]   count;
  logic [PW-1:0]   top_idx;

  assign top_idx = ptr - 1'b1;
  assign top     = entries[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
    end else begin
      unique case (op)
        RAS_PUSH: begin
          entries[ptr] <= push_data;
          ptr          <= ptr + 1'b1;
          if (!full) count <= count + 1'b1;
        end
        RAS_POP: begin
          if (!empty) begin
            ptr   <= top_idx;
            count <= count - 1'b1;
          end
        end
        RAS_POPPUSH: begin
          // Replace the top in place; on an empty stack this is a plain push.
          if (!empty) begin
            entries[top_idx] <= push_data;
          end else begin
            entries[ptr] <= push_data;
            ptr          <= ptr + 1'b1;
            count        <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/branch_target_unit.sv
// Branch/jump target generator with return-address stack prediction.
//   in_valid/in_ready   : decode handshake (pc, rs1, imm, instr_type,
//                         is_branch, rd_addr, rs1_addr)
//   out_valid/out_ready : result handshake (pc_target, flag_branch,
//                         misaligned, ras_hit, ras_pred)
//   flush               : drops the output stage and any same-cycle accept
//   ras_empty           : live RAS occupancy is zero
module branch_target_unit
  import btu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RAS_DEPTH   = 4,
  parameter int IALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [2:0]      instr_type,
  input  logic            is_branch,
  input  logic [4:0]      rd_addr,
  input  logic [4:0]      rs1_addr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_target,
  output logic [1:0]      flag_branch,
  output logic            misaligned,
  output logic            ras_hit,
  output logic [XLEN-1:0] ras_pred,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [XLEN-1:0] target_d;
  flag_e           flag_d;
  ras_op_e         op_d;
  ras_op_e         stack_op;
  logic            accept;
  logic            pop_d;
  logic            misaligned_d;
  logic            hit_d;
  logic [XLEN-1:0] pred_d;
  logic [XLEN-1:0] ret_addr;
  logic [XLEN-1:0] ras_top;
  logic            ras_full;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign ret_addr = pc + XLEN'(4);

  always_comb begin
    target_d = '0;
    flag_d   = FLAG_NONE;
    op_d     = RAS_NONE;
    unique case (instr_type_e'(instr_type))
      J_TYPE: begin
        target_d = pc + imm;
        flag_d   = FLAG_JAL;
        if (is_link(rd_addr)) op_d = RAS_PUSH;
      end
      B_TYPE: begin
        target_d = pc + imm;
        flag_d   = FLAG_BR;
      end
      I_TYPE: begin
        if (is_branch) begin
          target_d = (rs1 + imm) & JALR_MASK;
          flag_d   = FLAG_JALR;
          case ({is_link(rd_addr), is_link(rs1_addr)})
            2'b01:   op_d = RAS_POP;
            2'b10:   op_d = RAS_PUSH;
            2'b11:   op_d = (rd_addr == rs1_addr) ? RAS_PUSH : RAS_POPPUSH;
            default: op_d = RAS_NONE;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign stack_op     = accept ? op_d : RAS_NONE;
  assign pop_d        = (op_d == RAS_POP) || (op_d == RAS_POPPUSH);
  assign pred_d       = (pop_d && !ras_empty) ? ras_top : '0;
  assign hit_d        = pop_d && !ras_empty && (ras_top == target_d);
  assign misaligned_d = (flag_d != FLAG_NONE) && (target_d[IALIGN_BITS-1:0] != '0);

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (stack_op),
    .push_data (ret_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      pc_target   <= '0;
      flag_branch <= FLAG_NONE;
      misaligned  <= 1'b0;
      ras_hit     <= 1'b0;
      ras_pred    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      pc_target   <= target_d;
      flag_branch <= flag_d;
      misaligned  <= misaligned_d;
      ras_hit     <= hit_d;
      ras_pred    <= pred_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
